// File: rtl/cmd_feeder_pkg.sv
// Shared definitions for the command feeder.
//   CMD_W            : width of a Control command {sel_a, sel_b, opcode}
//   IDLE_CMD_DEFAULT : command presented while a transaction runs as a bubble
//   slot_state_t     : transaction-slot states (idle / locked on a real entry / bubble)
//   entry_width()    : width of one packed FIFO entry {cmd, a, b} for a given operand width
package cmd_feeder_pkg;

    localparam int CMD_W = 6;
    localparam logic [CMD_W-1:0] IDLE_CMD_DEFAULT = 6'b000000;

    // SLOT_REAL and SLOT_BUBBLE both mean "slot_busy"; the split records
    // whether the locked transaction owns the FIFO head (lock_used).
    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_REAL   = 2'd1,
        SLOT_BUBBLE = 2'd2
    } slot_state_t;

    // Entries are packed as {cmd[CMD_W-1:0], a[data_w-1:0], b[data_w-1:0]}.
    function automatic int entry_width(input int data_w);
        return CMD_W + 2 * data_w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular FIFO holding packed command entries.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : entry to write
//   pop        : advance the head (ignored when empty)
//   head_data  : entry at the head, combinational from storage
//   count      : number of stored entries, 0..DEPTH
//   empty      : count == 0
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/cmd_feeder.sv
// Command/operand buffer feeding the Control sequencer and ALU datapath.
//   clk, rst        : clock, synchronous active-high reset
//   s_valid/s_ready : upstream entry handshake
//   s_cmd/s_data_a/s_data_b : upstream entry fields
//   datain_reg_en   : Control transaction start strobe (locks the slot)
//   aluout_reg_en   : Control transaction end strobe (releases the slot)
//   cmd_out, data_a_out, data_b_out : entry presented to Control/datapath
//   slot_busy       : a transaction is in progress
//   exec_count      : transactions executed on a real entry (saturating)
//   bubble_count    : transactions executed as bubbles (saturating)
//   slot_state_dbg  : current slot state, for observation only
//
// Handshake: an upstream entry transfers on every rising edge where
// s_valid && s_ready. s_ready depends only on the registered FIFO count, so a
// pop on the same edge never frees room for a push while full.
module cmd_feeder
    import cmd_feeder_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               DATA_W   = 8,
    parameter logic [CMD_W-1:0] IDLE_CMD = IDLE_CMD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CMD_W-1:0]   s_cmd,
    input  logic [DATA_W-1:0]  s_data_a,
    input  logic [DATA_W-1:0]  s_data_b,
    input  logic               datain_reg_en,
    input  logic               aluout_reg_en,
    output logic [CMD_W-1:0]   cmd_out,
    output logic [DATA_W-1:0]  data_a_out,
    output logic [DATA_W-1:0]  data_b_out,
    output logic               slot_busy,
    output logic [15:0]        exec_count,
    output logic [15:0]        bubble_count,
    output logic [1:0]         slot_state_dbg
);

    localparam int ENTRY_W = entry_width(DATA_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    slot_state_t        state_q;
    slot_state_t        state_d;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head_data;
    logic               bubble_done;
    logic               show_head;

    assign s_ready   = (fifo_count < DEPTH_C);
    assign fifo_push = s_valid && s_ready;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({s_cmd, s_data_a, s_data_b}),
        .pop       (fifo_pop),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock decision uses head presence in the datain_reg_en cycle; a push that
    // lands later cannot turn a bubble into a real transaction.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        bubble_done = 1'b0;
        case (state_q)
            SLOT_IDLE: begin
                if (datain_reg_en) begin
                    state_d = fifo_empty ? SLOT_BUBBLE : SLOT_REAL;
                end
            end
            SLOT_REAL: begin
                if (aluout_reg_en) begin
                    state_d  = SLOT_IDLE;
                    fifo_pop = 1'b1;
                end
            end
            SLOT_BUBBLE: begin
                if (aluout_reg_en) begin
                    state_d     = SLOT_IDLE;
                    bubble_done = 1'b1;
                end
            end
            default: state_d = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exec_count   <= '0;
            bubble_count <= '0;
        end else begin
            if (fifo_pop && (exec_count != 16'hFFFF)) begin
                exec_count <= exec_count + 16'd1;
            end
            if (bubble_done && (bubble_count != 16'hFFFF)) begin
                bubble_count <= bubble_count + 16'd1;
            end
        end
    end

    // While locked on a real entry the head cannot move, so showing the head
    // keeps the outputs stable for the whole transaction.
    assign show_head = (state_q == SLOT_REAL) || ((state_q == SLOT_IDLE) && !fifo_empty);

    assign cmd_out        = show_head ? head_data[ENTRY_W-1 -: CMD_W] : IDLE_CMD;
    assign data_a_out     = show_head ? head_data[2*DATA_W-1 -: DATA_W] : '0;
    assign data_b_out     = show_head ? head_data[DATA_W-1:0] : '0;
    assign slot_busy      = (state_q != SLOT_IDLE);
    assign slot_state_dbg = state_q;

endmodule

// File: tb/tb_cmd_feeder.sv
// Self-checking bench for cmd_feeder. The main process drives upstream pushes
// and Control transactions and pushes the entry each transaction must present
// into exp_q; the monitor pops it when a transaction locks and checks the
// outputs on every cycle the slot is held.
module tb_cmd_feeder;
    localparam int W = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [5:0]  s_cmd = '0;
    logic [7:0]  s_data_a = '0;
    logic [7:0]  s_data_b = '0;
    logic        datain_reg_en = 1'b0;
    logic        aluout_reg_en = 1'b0;
    logic [5:0]  cmd_out;
    logic [7:0]  data_a_out;
    logic [7:0]  data_b_out;
    logic        slot_busy;
    logic [15:0] exec_count;
    logic [15:0] bubble_count;
    logic [1:0]  slot_state_dbg;

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    bit mon_active = 1'b0;

    cmd_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_cmd          (s_cmd),
        .s_data_a       (s_data_a),
        .s_data_b       (s_data_b),
        .datain_reg_en  (datain_reg_en),
        .aluout_reg_en  (aluout_reg_en),
        .cmd_out        (cmd_out),
        .data_a_out     (data_a_out),
        .data_b_out     (data_b_out),
        .slot_busy      (slot_busy),
        .exec_count     (exec_count),
        .bubble_count   (bubble_count),
        .slot_state_dbg (slot_state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] cur;
        int rem;
        cur = '0;
        rem = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (mon_active) begin
                chk("hold", {cmd_out, data_a_out, data_b_out}, cur);
                rem--;
                if (rem == 0) mon_active = 1'b0;
            end else if (datain_reg_en && !slot_busy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL exp_q_underflow: got lock, expected none");
                end else begin
                    cur = exp_q.pop_front();
                    chk("lock", {cmd_out, data_a_out, data_b_out}, cur);
                    mon_active = 1'b1;
                    rem = 2;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [W-1:0] e);
        int n;
        n = 0;
        s_valid = 1'b1;
        {s_cmd, s_data_a, s_data_b} = e;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: s_ready 0 expected 1");
        end
        step();
        s_valid = 1'b0;
    endtask

    // One Control transaction: CMD_IN, datain, aluin, aluout cycles. Returns at
    // the start of the cycle after release. Optionally pushes in the aluin cycle.
    task automatic ctl_txn(input bit mid_push, input logic [W-1:0] e);
        step();
        datain_reg_en = 1'b1;
        step();
        datain_reg_en = 1'b0;
        if (mid_push) begin
            s_valid = 1'b1;
            {s_cmd, s_data_a, s_data_b} = e;
        end
        step();
        if (mid_push) s_valid = 1'b0;
        aluout_reg_en = 1'b1;
        step();
        aluout_reg_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [W-1:0] e [8];
        e[0] = {6'h36, 8'h12, 8'h34};
        e[1] = {6'h01, 8'h11, 8'h21};
        e[2] = {6'h02, 8'h12, 8'h22};
        e[3] = {6'h03, 8'h13, 8'h23};
        e[4] = {6'h04, 8'h14, 8'h24};
        e[5] = {6'h07, 8'h17, 8'h27};
        e[6] = {6'h05, 8'hAA, 8'h55};
        e[7] = {6'h2A, 8'hC3, 8'h3C};

        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_slot_busy", 32'(slot_busy), 32'd0);
        chk("rst_outputs", 32'({cmd_out, data_a_out, data_b_out}), 32'd0);
        chk("rst_exec", 32'(exec_count), 32'd0);
        chk("rst_bubble", 32'(bubble_count), 32'd0);

        // four bubble transactions with nothing queued
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('0);
            ctl_txn(1'b0, '0);
        end
        chk("bubble4_bubble", 32'(bubble_count), 32'd4);
        chk("bubble4_exec", 32'(exec_count), 32'd0);

        // single entry while idle
        push_entry(e[0]);
        chk("single_present", 32'({cmd_out, data_a_out, data_b_out}), 32'(e[0]));
        exp_q.push_back(e[0]);
        ctl_txn(1'b0, '0);
        chk("single_exec", 32'(exec_count), 32'd1);
        chk("single_s_ready", 32'(s_ready), 32'd1);
        chk("single_popped", 32'(cmd_out), 32'h00);

        // fill, hold a fifth entry across the release edge, then drain
        for (int i = 1; i <= 4; i++) push_entry(e[i]);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        {s_cmd, s_data_a, s_data_b} = e[5];
        step();
        step();
        chk("full_held_off", 32'(s_ready), 32'd0);
        chk("full_head", 32'(cmd_out), 32'h01);
        exp_q.push_back(e[1]);
        ctl_txn(1'b0, '0);
        chk("release_s_ready", 32'(s_ready), 32'd1);
        chk("release_exec", 32'(exec_count), 32'd2);
        step();
        s_valid = 1'b0;
        chk("refill_s_ready", 32'(s_ready), 32'd0);
        chk("refill_head", 32'(cmd_out), 32'h02);
        for (int i = 2; i <= 5; i++) begin
            exp_q.push_back(e[i]);
            ctl_txn(1'b0, '0);
        end
        chk("drain_exec", 32'(exec_count), 32'd6);
        chk("drain_empty", 32'(cmd_out), 32'h00);

        // push lands mid-bubble: stays IDLE, shows on the next CMD_IN cycle
        exp_q.push_back('0);
        ctl_txn(1'b1, e[6]);
        chk("late_bubble", 32'(bubble_count), 32'd5);
        chk("late_present", 32'({cmd_out, data_a_out, data_b_out}), 32'(e[6]));
        exp_q.push_back(e[6]);
        ctl_txn(1'b0, '0);
        chk("late_exec", 32'(exec_count), 32'd7);

        // reset in the aluin cycle of a real transaction
        push_entry(e[7]);
        exp_q.push_back(e[7]);
        step();
        datain_reg_en = 1'b1;
        step();
        datain_reg_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_slot_busy", 32'(slot_busy), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd1);
        chk("abort_cmd", 32'(cmd_out), 32'h00);
        chk("abort_exec", 32'(exec_count), 32'd0);
        chk("abort_bubble", 32'(bubble_count), 32'd0);

        // stray aluout_reg_en while idle is ignored
        push_entry({6'h3F, 8'hFF, 8'h00});
        aluout_reg_en = 1'b1;
        step();
        aluout_reg_en = 1'b0;
        chk("stray_cmd", 32'(cmd_out), 32'h3F);
        chk("stray_exec", 32'(exec_count), 32'd0);
        exp_q.push_back({6'h3F, 8'hFF, 8'h00});
        ctl_txn(1'b0, '0);
        chk("stray_then_exec", 32'(exec_count), 32'd1);
        chk("stray_then_empty", 32'(cmd_out), 32'h00);

        step();
        step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $finish;
    end

endmodule
